// File: rtl/mram_pkg.sv
// Shared encodings for the MRAM arbiter: FSM states, one-hot grant values, byte-select width.
// ST_HIT exists only when MRAM_ARB_RDBUF_EN is defined.
package mram_pkg;

  localparam int SEL_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
`ifdef MRAM_ARB_RDBUF_EN
  localparam logic [1:0] ST_HIT  = 2'd3;
`endif

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  function automatic logic [1:0] grantOf(input logic pickB);
    return pickB ? GRANT_B : GRANT_A;
  endfunction

endpackage

// File: rtl/mram_rdbuf.sv
// One-word read buffer (valid/adr/data) used by mram_arbiter under MRAM_ARB_RDBUF_EN.
// Loads on a read ack; a granted write to the buffered address invalidates it.
module mram_rdbuf #(
  parameter int ADR_W = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             loadEn,
  input  logic [ADR_W-1:0] loadAdr,
  input  logic [31:0]      loadDat,
  input  logic [ADR_W-1:0] lookAdr,
  input  logic             clrEn,
  output logic             hit,
  output logic [31:0]      bufDat
);

  logic             bufVld;
  logic [ADR_W-1:0] bufAdr;

  assign hit = bufVld && (lookAdr == bufAdr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bufVld <= 1'b0;
    end else if (loadEn) begin
      bufVld <= 1'b1;
    end else if (clrEn && hit) begin
      bufVld <= 1'b0;
    end
  end

  // Contents are only meaningful while bufVld is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (loadEn) begin
      bufAdr <= loadAdr;
      bufDat <= loadDat;
    end
  end

endmodule

// File: rtl/mram_arbiter.sv
// Two-master arbiter in front of the MRAM controller: request-to-m_stb_o latency 1 cycle, 1 GAP cycle after each ack.
// The losing master simply waits with stb high; MRAM_ARB_RDBUF_EN adds a one-word read buffer with a HIT path.
module mram_arbiter
  import mram_pkg::*;
#(
  parameter int DEFAULT_PRIO = 0,
  parameter int ADR_W        = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_stb_i,
  input  logic             a_we_i,
  input  logic [SEL_W-1:0] a_sel_i,
  input  logic [31:0]      a_dat_i,
  input  logic [ADR_W-1:0] a_adr_i,
  output logic [31:0]      a_dat_o,
  output logic             a_ack_o,
  input  logic             b_stb_i,
  input  logic             b_we_i,
  input  logic [SEL_W-1:0] b_sel_i,
  input  logic [31:0]      b_dat_i,
  input  logic [ADR_W-1:0] b_adr_i,
  output logic [31:0]      b_dat_o,
  output logic             b_ack_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [SEL_W-1:0] m_sel_o,
  output logic [31:0]      m_dat_o,
  output logic [ADR_W-1:0] m_adr_o,
  input  logic [31:0]      m_dat_i,
  input  logic             m_ack_i,
  output logic [1:0]       grant_o
);

  logic [1:0]       state;
  logic [1:0]       grantReg;
  logic             lastB;
  logic             latWe;
  logic [SEL_W-1:0] latSel;
  logic [31:0]      latDat;
  logic [ADR_W-1:0] latAdr;

  logic             anyReq;
  logic             bothReq;
  logic             pickB;
  logic             winWe;
  logic [SEL_W-1:0] winSel;
  logic [31:0]      winDat;
  logic [ADR_W-1:0] winAdr;
  logic             slaveAck;
  logic             ackAny;
  logic [31:0]      rdDat;
  logic [1:0]       grantState;

  assign anyReq  = a_stb_i | b_stb_i;
  assign bothReq = a_stb_i & b_stb_i;
  assign pickB   = b_stb_i & (~a_stb_i | ~lastB);
  assign winWe   = pickB ? b_we_i  : a_we_i;
  assign winSel  = pickB ? b_sel_i : a_sel_i;
  assign winDat  = pickB ? b_dat_i : a_dat_i;
  assign winAdr  = pickB ? b_adr_i : a_adr_i;

  assign m_stb_o  = (state == ST_BUSY);
  assign m_we_o   = latWe;
  assign m_sel_o  = latSel;
  assign m_dat_o  = latDat;
  assign m_adr_o  = latAdr;
  assign grant_o  = grantReg;
  assign slaveAck = m_stb_o & m_ack_i;

`ifdef MRAM_ARB_RDBUF_EN
  logic        inHit;
  logic        bufHit;
  logic [31:0] bufDat;

  assign inHit      = (state == ST_HIT);
  assign ackAny     = slaveAck | inHit;
  assign rdDat      = inHit ? bufDat : m_dat_i;
  assign grantState = (~winWe & bufHit) ? ST_HIT : ST_BUSY;

  mram_rdbuf #(
    .ADR_W (ADR_W)
  ) u_rdbuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .loadEn  (slaveAck & ~latWe),
    .loadAdr (latAdr),
    .loadDat (m_dat_i),
    .lookAdr (winAdr),
    .clrEn   ((state == ST_IDLE) & anyReq & winWe),
    .hit     (bufHit),
    .bufDat  (bufDat)
  );
`else
  assign ackAny     = slaveAck;
  assign rdDat      = m_dat_i;
  assign grantState = ST_BUSY;
`endif

  assign a_ack_o = ackAny & grantReg[0];
  assign b_ack_o = ackAny & grantReg[1];
  assign a_dat_o = rdDat;
  assign b_dat_o = rdDat;

  // Priority only moves on a contested grant, so a lone requester does not use up its turn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      grantReg <= GRANT_NONE;
      lastB    <= (DEFAULT_PRIO == 0);
    end else begin
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            state    <= grantState;
            grantReg <= grantOf(pickB);
            if (bothReq) lastB <= pickB;
          end
        end
        ST_BUSY: begin
          if (m_ack_i) begin
            state    <= ST_GAP;
            grantReg <= GRANT_NONE;
          end
        end
`ifdef MRAM_ARB_RDBUF_EN
        ST_HIT: begin
          state    <= ST_GAP;
          grantReg <= GRANT_NONE;
        end
`endif
        ST_GAP: begin
          state    <= ST_IDLE;
          grantReg <= GRANT_NONE;
        end
        default: begin
          state    <= ST_IDLE;
          grantReg <= GRANT_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state == ST_IDLE) && anyReq) begin
      latWe  <= winWe;
      latSel <= winSel;
      latDat <= winDat;
      latAdr <= winAdr;
    end
  end

endmodule

// File: tb/tb_mram_arbiter.sv
// Directed self-checking bench for mram_arbiter; the read-buffer scenario adapts to MRAM_ARB_RDBUF_EN.
module tb_mram_arbiter;

  localparam int ADR_W = 30;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             a_stb_i, a_we_i, a_ack_o;
  logic [3:0]       a_sel_i;
  logic [31:0]      a_dat_i, a_dat_o;
  logic [ADR_W-1:0] a_adr_i;
  logic             b_stb_i, b_we_i, b_ack_o;
  logic [3:0]       b_sel_i;
  logic [31:0]      b_dat_i, b_dat_o;
  logic [ADR_W-1:0] b_adr_i;
  logic             m_stb_o, m_we_o, m_ack_i;
  logic [3:0]       m_sel_o;
  logic [31:0]      m_dat_o, m_dat_i;
  logic [ADR_W-1:0] m_adr_o;
  logic [1:0]       grant_o;

  int passCnt  = 0;
  int totalCnt = 0;

  mram_arbiter #(.DEFAULT_PRIO(0), .ADR_W(ADR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_stb_i(a_stb_i), .a_we_i(a_we_i), .a_sel_i(a_sel_i), .a_dat_i(a_dat_i),
    .a_adr_i(a_adr_i), .a_dat_o(a_dat_o), .a_ack_o(a_ack_o),
    .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_sel_i(b_sel_i), .b_dat_i(b_dat_i),
    .b_adr_i(b_adr_i), .b_dat_o(b_dat_o), .b_ack_o(b_ack_o),
    .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
    .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    a_stb_i = 0; a_we_i = 0; a_sel_i = 4'h0; a_dat_i = 0; a_adr_i = 0;
    b_stb_i = 0; b_we_i = 0; b_sel_i = 4'h0; b_dat_i = 0; b_adr_i = 0;
    m_ack_i = 0; m_dat_i = 0;
  endtask

  task automatic reqA(input logic we, input logic [3:0] sel, input logic [31:0] dat, input logic [ADR_W-1:0] adr);
    a_stb_i = 1; a_we_i = we; a_sel_i = sel; a_dat_i = dat; a_adr_i = adr;
  endtask

  task automatic reqB(input logic we, input logic [3:0] sel, input logic [31:0] dat, input logic [ADR_W-1:0] adr);
    b_stb_i = 1; b_we_i = we; b_sel_i = sel; b_dat_i = dat; b_adr_i = adr;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_i = 1;
    #3;
    totalCnt++; if (m_stb_o !== 1'b0) $display("FAIL rst_stb: got %b want 0", m_stb_o); else passCnt++;
    totalCnt++; if (grant_o !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant_o); else passCnt++;
    totalCnt++; if (a_ack_o !== 1'b0) $display("FAIL rst_a_ack: got %b want 0", a_ack_o); else passCnt++;
    totalCnt++; if (b_ack_o !== 1'b0) $display("FAIL rst_b_ack: got %b want 0", b_ack_o); else passCnt++;
    tick();
    rst_i = 0;
    tick();
  endtask

  task automatic test_a_read();
    logic quiet;
    reqA(1'b0, 4'hF, 32'h0, 30'h10);
    tick();
    totalCnt++; if (m_stb_o !== 1'b1) $display("FAIL ard_stb: got %b want 1", m_stb_o); else passCnt++;
    totalCnt++; if (m_adr_o !== 30'h10) $display("FAIL ard_adr: got %h want 10", m_adr_o); else passCnt++;
    totalCnt++; if (m_we_o !== 1'b0) $display("FAIL ard_we: got %b want 0", m_we_o); else passCnt++;
    totalCnt++; if (grant_o !== 2'b01) $display("FAIL ard_grant: got %b want 01", grant_o); else passCnt++;
    quiet = 1'b1;
    for (int i = 0; i < 59; i++) begin
      if (m_stb_o !== 1'b1 || a_ack_o !== 1'b0 || b_ack_o !== 1'b0 || m_adr_o !== 30'h10) quiet = 1'b0;
      tick();
    end
    totalCnt++; if (quiet !== 1'b1) $display("FAIL ard_wait: got %b want 1", quiet); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'hDEADBEEF;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1) $display("FAIL ard_ack: got %b want 1", a_ack_o); else passCnt++;
    totalCnt++; if (a_dat_o !== 32'hDEADBEEF) $display("FAIL ard_dat: got %h want deadbeef", a_dat_o); else passCnt++;
    totalCnt++; if (b_ack_o !== 1'b0) $display("FAIL ard_b_ack: got %b want 0", b_ack_o); else passCnt++;
    tick();
    // Slave ack is still high here, in GAP: it must be ignored.
    totalCnt++; if (a_ack_o !== 1'b0) $display("FAIL ard_ack_once: got %b want 0", a_ack_o); else passCnt++;
    totalCnt++; if (m_stb_o !== 1'b0) $display("FAIL ard_gap_stb: got %b want 0", m_stb_o); else passCnt++;
    totalCnt++; if (grant_o !== 2'b00) $display("FAIL ard_gap_grant: got %b want 00", grant_o); else passCnt++;
    idleInputs();
    tick();
    totalCnt++; if (m_stb_o !== 1'b0) $display("FAIL ard_idle_stb: got %b want 0", m_stb_o); else passCnt++;
  endtask

  task automatic test_round_robin();
    #2 rst_i = 1;
    #2 rst_i = 0;
    tick();
    reqA(1'b0, 4'hF, 32'h0, 30'h100);
    reqB(1'b0, 4'hF, 32'h0, 30'h200);
    tick();
    totalCnt++; if (grant_o !== 2'b01) $display("FAIL rr1_grant: got %b want 01", grant_o); else passCnt++;
    totalCnt++; if (m_adr_o !== 30'h100) $display("FAIL rr1_adr: got %h want 100", m_adr_o); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'h1111;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1 || b_ack_o !== 1'b0) $display("FAIL rr1_ack: got a=%b b=%b want a=1 b=0", a_ack_o, b_ack_o); else passCnt++;
    tick();
    m_ack_i = 0; a_stb_i = 0;
    totalCnt++; if (m_stb_o !== 1'b0 || grant_o !== 2'b00) $display("FAIL rr1_gap: got stb=%b grant=%b want 0/00", m_stb_o, grant_o); else passCnt++;
    tick();
    totalCnt++; if (m_stb_o !== 1'b0) $display("FAIL rr1_idle: got %b want 0", m_stb_o); else passCnt++;
    tick();
    totalCnt++; if (grant_o !== 2'b10 || m_adr_o !== 30'h200) $display("FAIL rr2_grant: got %b/%h want 10/200", grant_o, m_adr_o); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'h2222;
    #1;
    totalCnt++; if (b_ack_o !== 1'b1 || a_ack_o !== 1'b0 || b_dat_o !== 32'h2222) $display("FAIL rr2_ack: got b=%b a=%b dat=%h want 1/0/2222", b_ack_o, a_ack_o, b_dat_o); else passCnt++;
    tick();
    m_ack_i = 0; b_stb_i = 0;
    tick();
    reqA(1'b0, 4'hF, 32'h0, 30'h104);
    reqB(1'b0, 4'hF, 32'h0, 30'h204);
    tick();
    totalCnt++; if (grant_o !== 2'b10 || m_adr_o !== 30'h204) $display("FAIL rr3_grant: got %b/%h want 10/204", grant_o, m_adr_o); else passCnt++;
    m_ack_i = 1;
    #1;
    totalCnt++; if (b_ack_o !== 1'b1 || a_ack_o !== 1'b0) $display("FAIL rr3_ack: got b=%b a=%b want 1/0", b_ack_o, a_ack_o); else passCnt++;
    tick();
    m_ack_i = 0; b_stb_i = 0;
    tick();
    tick();
    totalCnt++; if (grant_o !== 2'b01 || m_adr_o !== 30'h104) $display("FAIL rr4_grant: got %b/%h want 01/104", grant_o, m_adr_o); else passCnt++;
    m_ack_i = 1;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1) $display("FAIL rr4_ack: got %b want 1", a_ack_o); else passCnt++;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_write_hold();
    logic stable;
    reqA(1'b1, 4'b0010, 32'h0000AB00, 30'h40);
    tick();
    a_sel_i = 4'hF; a_dat_i = 32'hFFFFFFFF;
    reqB(1'b0, 4'hF, 32'h0, 30'h44);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (m_stb_o !== 1'b1 || grant_o !== 2'b01 || m_sel_o !== 4'b0010 || m_dat_o !== 32'h0000AB00 ||
          m_we_o !== 1'b1 || m_adr_o !== 30'h40 || b_ack_o !== 1'b0) stable = 1'b0;
      tick();
    end
    totalCnt++; if (stable !== 1'b1) $display("FAIL wr_stable: got %b want 1", stable); else passCnt++;
    m_ack_i = 1;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1 || b_ack_o !== 1'b0) $display("FAIL wr_ack: got a=%b b=%b want 1/0", a_ack_o, b_ack_o); else passCnt++;
    tick();
    m_ack_i = 0; a_stb_i = 0;
    totalCnt++; if (m_stb_o !== 1'b0 || grant_o !== 2'b00) $display("FAIL wr_gap: got stb=%b grant=%b want 0/00", m_stb_o, grant_o); else passCnt++;
    tick();
    totalCnt++; if (m_stb_o !== 1'b0) $display("FAIL wr_idle: got %b want 0", m_stb_o); else passCnt++;
    tick();
    totalCnt++; if (m_stb_o !== 1'b1 || grant_o !== 2'b10 || m_adr_o !== 30'h44 || m_we_o !== 1'b0)
      $display("FAIL wr_b_grant: got stb=%b grant=%b adr=%h we=%b want 1/10/44/0", m_stb_o, grant_o, m_adr_o, m_we_o); else passCnt++;
    m_ack_i = 1;
    #1;
    totalCnt++; if (b_ack_o !== 1'b1) $display("FAIL wr_b_ack: got %b want 1", b_ack_o); else passCnt++;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    reqA(1'b0, 4'hF, 32'h0, 30'h80);
    tick();
    totalCnt++; if (m_stb_o !== 1'b1) $display("FAIL rb_stb: got %b want 1", m_stb_o); else passCnt++;
    #2;
    rst_i = 1; m_ack_i = 1;
    #1;
    totalCnt++; if (m_stb_o !== 1'b0 || grant_o !== 2'b00) $display("FAIL rb_async: got stb=%b grant=%b want 0/00", m_stb_o, grant_o); else passCnt++;
    totalCnt++; if (a_ack_o !== 1'b0) $display("FAIL rb_noack: got %b want 0", a_ack_o); else passCnt++;
    #2;
    rst_i = 0; m_ack_i = 0; a_stb_i = 0;
    tick();
    reqA(1'b0, 4'hF, 32'h0, 30'h84);
    tick();
    totalCnt++; if (grant_o !== 2'b01 || m_adr_o !== 30'h84) $display("FAIL rb_again: got %b/%h want 01/84", grant_o, m_adr_o); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'h0BADF00D;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1 || a_dat_o !== 32'h0BADF00D) $display("FAIL rb_ack: got %b/%h want 1/0badf00d", a_ack_o, a_dat_o); else passCnt++;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_stb_drop();
    logic held;
    reqA(1'b0, 4'hF, 32'h0, 30'h90);
    tick();
    a_stb_i = 0;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_stb_o !== 1'b1 || grant_o !== 2'b01) held = 1'b0;
    end
    totalCnt++; if (held !== 1'b1) $display("FAIL drop_held: got %b want 1", held); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'hCAFE0001;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1 || a_dat_o !== 32'hCAFE0001) $display("FAIL drop_ack: got %b/%h want 1/cafe0001", a_ack_o, a_dat_o); else passCnt++;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_ack_idle();
    logic silent;
    m_ack_i = 1;
    silent = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_ack_o !== 1'b0 || b_ack_o !== 1'b0 || m_stb_o !== 1'b0) silent = 1'b0;
      tick();
    end
    totalCnt++; if (silent !== 1'b1) $display("FAIL idle_ack: got %b want 1", silent); else passCnt++;
    m_ack_i = 0;
    tick();
  endtask

  task automatic test_rdbuf();
    reqA(1'b0, 4'hF, 32'h0, 30'h20);
    tick();
    m_ack_i = 1; m_dat_i = 32'h12345678;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1 || a_dat_o !== 32'h12345678) $display("FAIL buf_fill: got %b/%h want 1/12345678", a_ack_o, a_dat_o); else passCnt++;
    tick();
    idleInputs();
    tick();
    reqB(1'b0, 4'hF, 32'h0, 30'h20);
    tick();
`ifdef MRAM_ARB_RDBUF_EN
    totalCnt++; if (b_ack_o !== 1'b1 || b_dat_o !== 32'h12345678) $display("FAIL buf_hit: got %b/%h want 1/12345678", b_ack_o, b_dat_o); else passCnt++;
    totalCnt++; if (m_stb_o !== 1'b0 || a_ack_o !== 1'b0) $display("FAIL buf_hit_stb: got stb=%b a=%b want 0/0", m_stb_o, a_ack_o); else passCnt++;
    tick();
    b_stb_i = 0;
    totalCnt++; if (b_ack_o !== 1'b0 || m_stb_o !== 1'b0) $display("FAIL buf_hit_gap: got ack=%b stb=%b want 0/0", b_ack_o, m_stb_o); else passCnt++;
`else
    totalCnt++; if (m_stb_o !== 1'b1 || b_ack_o !== 1'b0 || m_adr_o !== 30'h20) $display("FAIL nobuf_rd: got stb=%b ack=%b adr=%h want 1/0/20", m_stb_o, b_ack_o, m_adr_o); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'h12345678;
    #1;
    totalCnt++; if (b_ack_o !== 1'b1) $display("FAIL nobuf_ack: got %b want 1", b_ack_o); else passCnt++;
    tick();
    idleInputs();
`endif
    tick();
    reqB(1'b1, 4'b0001, 32'h55, 30'h20);
    tick();
    totalCnt++; if (m_stb_o !== 1'b1 || m_we_o !== 1'b1) $display("FAIL buf_wr: got stb=%b we=%b want 1/1", m_stb_o, m_we_o); else passCnt++;
    m_ack_i = 1;
    #1;
    tick();
    idleInputs();
    tick();
    reqA(1'b0, 4'hF, 32'h0, 30'h20);
    tick();
    totalCnt++; if (m_stb_o !== 1'b1 || a_ack_o !== 1'b0 || m_adr_o !== 30'h20) $display("FAIL buf_miss: got stb=%b ack=%b adr=%h want 1/0/20", m_stb_o, a_ack_o, m_adr_o); else passCnt++;
    m_ack_i = 1; m_dat_i = 32'h99;
    #1;
    totalCnt++; if (a_ack_o !== 1'b1 || a_dat_o !== 32'h99) $display("FAIL buf_miss_ack: got %b/%h want 1/99", a_ack_o, a_dat_o); else passCnt++;
    tick();
    idleInputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_a_read();
    test_round_robin();
    test_write_hold();
    test_reset_mid_busy();
    test_stb_drop();
    test_ack_idle();
    test_rdbuf();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
